// File: rtl/store_queue.sv
// Speculative store queue: circular buffer split into committed and speculative regions,
// draining committed stores to memory. Define STORE_QUEUE_FORWARD_EN for store-to-load forwarding.
module store_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8,
    parameter int CMT_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic [CMT_W-1:0]         commit_cnt,
    input  logic [ADDR_W-1:0]        search_addr,
    output logic [DATA_W-1:0]        search_data,
    output logic                     search_hit,
    output logic                     mem_valid,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data,
    input  logic                     mem_ready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CW    = (CMT_W > CNT_W) ? CMT_W : CNT_W;

    logic [PTR_W-1:0]  r_head, r_cmt, r_tail;
    logic [CNT_W-1:0]  r_count, r_ccnt;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    logic              w_enq, w_pop;
    logic [CNT_W-1:0]  w_spec, w_cmt_n, w_ccnt_next;

    assign in_ready  = (r_count < CNT_W'(DEPTH));
    assign mem_valid = (r_ccnt != '0);
    assign w_enq     = in_valid && in_ready && !flush;
    assign w_pop     = mem_valid && mem_ready;
    assign w_spec    = r_count - r_ccnt;
    assign count     = r_count;

    // Commit saturates at the speculative population present before this edge.
    assign w_cmt_n     = (CW'(commit_cnt) < CW'(w_spec)) ? CNT_W'(commit_cnt) : w_spec;
    assign w_ccnt_next = r_ccnt + w_cmt_n - CNT_W'(w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_cmt   <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ccnt  <= '0;
        end else begin
            r_head <= r_head + PTR_W'(w_pop);
            r_cmt  <= r_cmt + PTR_W'(w_cmt_n);
            r_ccnt <= w_ccnt_next;
            if (flush) begin
                // Discard everything younger than the freshly advanced commit point.
                r_tail  <= r_cmt + PTR_W'(w_cmt_n);
                r_count <= w_ccnt_next;
            end else begin
                r_tail  <= r_tail + PTR_W'(w_enq);
                r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= in_addr;
            r_data[r_tail] <= in_data;
        end
    end

    assign mem_addr = mem_valid ? r_addr[r_head] : '0;
    assign mem_data = mem_valid ? r_data[r_head] : '0;

`ifdef STORE_QUEUE_FORWARD_EN
    logic [PTR_W-1:0] w_idx   [DEPTH];
    logic             w_match [DEPTH];

    // Slot gi holds the gi-th oldest entry; later matches override earlier ones.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign w_idx[gi]   = r_head + PTR_W'(gi);
        assign w_match[gi] = (CNT_W'(gi) < r_count) && (r_addr[w_idx[gi]] == search_addr);
    end

    always_comb begin
        search_hit  = 1'b0;
        search_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_match[k]) begin
                search_hit  = 1'b1;
                search_data = r_data[w_idx[k]];
            end
        end
    end
`else
    logic w_unused_search;
    assign w_unused_search = ^search_addr;
    assign search_hit      = 1'b0;
    assign search_data     = '0;
`endif
endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: a reference queue model acts as scoreboard,
// expected stores pushed on enqueue and popped when the memory handshake occurs.
module tb_store_queue;
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;

`ifdef STORE_QUEUE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, mem_valid, mem_ready, search_hit;
    logic [15:0] in_addr, in_data, search_addr, search_data, mem_addr, mem_data;
    logic [1:0]  commit_cnt;
    logic [3:0]  count;

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t m_q[$];
    int   m_c = 0;

    store_queue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready),
        .commit_cnt(commit_cnt), .search_addr(search_addr),
        .search_data(search_data), .search_hit(search_hit),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(mem_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic        e_hit;
        logic [15:0] e_data;
        e_hit  = 1'b0;
        e_data = '0;
        if (FWD) begin
            foreach (m_q[i]) begin
                if (m_q[i].a == search_addr) begin
                    e_hit  = 1'b1;
                    e_data = m_q[i].d;
                end
            end
        end
        chk("count", 16'(count), 16'(m_q.size()));
        chk("in_ready", 16'(in_ready), 16'(m_q.size() < 8));
        chk("mem_valid", 16'(mem_valid), 16'(m_c > 0));
        if (m_c > 0) begin
            chk("mem_addr", mem_addr, m_q[0].a);
            chk("mem_data", mem_data, m_q[0].d);
        end
        chk("search_hit", 16'(search_hit), 16'(e_hit));
        chk("search_data", search_data, e_data);
    endtask

    // One clock: check outputs at negedge, then apply the edge to the model.
    task automatic step();
        int   spec, cn;
        bit   pop, enq;
        ent_t e;
        @(negedge clk);
        check_outputs();
        spec = m_q.size() - m_c;
        cn   = (int'(commit_cnt) < spec) ? int'(commit_cnt) : spec;
        pop  = (m_c > 0) && mem_ready;
        enq  = in_valid && (m_q.size() < 8) && !flush;
        e.a  = in_addr;
        e.d  = in_data;
        if (pop) $display("tb: mem write addr=%h data=%h", mem_addr, mem_data);
        @(posedge clk);
        #1;
        m_c = m_c + cn - int'(pop);
        if (pop) void'(m_q.pop_front());
        if (flush) while (m_q.size() > m_c) void'(m_q.pop_back());
        if (enq) begin
            m_q.push_back(e);
            $display("tb: enqueue addr=%h data=%h", e.a, e.d);
        end
    endtask

    task automatic drain();
        in_valid = 0; flush = 0; commit_cnt = 2'd3; mem_ready = 1;
        for (int i = 0; i < 40 && m_q.size() > 0; i++) step();
        chk("drain_count", 16'(count), 16'd0);
        commit_cnt = 0; mem_ready = 0;
    endtask

    initial begin
        reset = 1; flush = 0; in_valid = 0; in_addr = 0; in_data = 0;
        commit_cnt = 0; search_addr = 16'h0010; mem_ready = 0;
        repeat (2) step();
        @(posedge clk); #1 reset = 0;

        // Forwarding: youngest match wins, no match yields zero.
        in_valid = 1; in_addr = 16'h0010; in_data = 16'h1111; step();
        in_data = 16'h2222; step();
        in_valid = 0; search_addr = 16'h0010; step();
        chk("fwd_hit_A", 16'(search_hit), 16'(FWD));
        chk("fwd_data_A", search_data, FWD ? 16'h2222 : 16'h0000);
        search_addr = 16'h0020; step();
        chk("fwd_hit_miss", 16'(search_hit), 16'd0);
        chk("fwd_data_miss", search_data, 16'h0000);
        drain();

        // Fill to full with in_valid held, then commit and pop.
        in_valid = 1;
        for (int i = 0; i < 9; i++) begin
            in_addr = 16'h0100 + 16'(i); in_data = 16'hA000 + 16'(i); step();
        end
        chk("full_ready", 16'(in_ready), 16'd0);
        chk("full_count", 16'(count), 16'd8);
        commit_cnt = 1; step();
        commit_cnt = 0; mem_ready = 1; in_addr = 16'h01F0; in_data = 16'hAFFF; step();
        mem_ready = 0; step();
        drain();

        // Memory back-pressure holds the offered store stable.
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_addr = 16'h0300 + 16'(i); in_data = 16'hB000 + 16'(i); step();
        end
        in_valid = 0; commit_cnt = 2; step();
        commit_cnt = 0;
        repeat (3) step();
        chk("stall_addr", mem_addr, 16'h0300);
        chk("stall_data", mem_data, 16'hB000);
        mem_ready = 1; repeat (2) step();
        chk("stall_drained", 16'(mem_valid), 16'd0);
        mem_ready = 0; step();
        drain();

        // Flush with same-edge commit keeps committed entries only.
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            in_addr = 16'h0400 + 16'(i); in_data = 16'hC000 + 16'(i); step();
        end
        in_valid = 0; commit_cnt = 1; step();
        flush = 1; in_valid = 1; in_addr = 16'h0499; step();
        flush = 0; in_valid = 0; commit_cnt = 0;
        chk("flush_count", 16'(count), 16'd2);
        search_addr = 16'h0403; step();
        chk("flush_unsearchable", 16'(search_hit), 16'd0);
        mem_ready = 1; repeat (2) step();
        mem_ready = 0;
        in_valid = 1; in_addr = 16'h0500; in_data = 16'hD000; step();
        in_valid = 0; commit_cnt = 3; step();
        commit_cnt = 0;
        chk("sat_commit_valid", 16'(mem_valid), 16'd1);
        step();
        drain();

        // Asynchronous reset mid-cycle with a store on offer.
        in_valid = 1; in_addr = 16'h0600; in_data = 16'hE000; step();
        in_addr = 16'h0601; step();
        in_valid = 0; commit_cnt = 3; step();
        commit_cnt = 0;
        chk("pre_reset_valid", 16'(mem_valid), 16'd1);
        #3 reset = 1;
        #1;
        chk("rst_count", 16'(count), 16'd0);
        chk("rst_mem_valid", 16'(mem_valid), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_search_hit", 16'(search_hit), 16'd0);
        m_q.delete(); m_c = 0;
        @(posedge clk); #1 reset = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
